// File: rtl/nauta_cal_ctrl.sv
// Configuration and SAR offset-calibration sequencer for one segmented Nauta transconductor.
// Holds the thermometer segment enables and trims the offset code from a comparator.
module nauta_cal_ctrl #(
    parameter int unsigned MULT     = 10,
    parameter int unsigned AUX      = 5,
    parameter int unsigned FB       = 4,
    parameter int unsigned OFS_W    = 4,
    parameter int unsigned SETTLE_W = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cfg_load,
    input  logic [$clog2(MULT+1)-1:0]  cfg_main,
    input  logic [$clog2(AUX+1)-1:0]   cfg_aux,
    input  logic [$clog2(FB+1)-1:0]    cfg_fb,
    input  logic [SETTLE_W-1:0]        cfg_settle,
    input  logic                       cal_start,
    input  logic                       comp_i,
    output logic [MULT-1:0]            main_en,
    output logic [AUX-1:0]             aux_en,
    output logic [FB-1:0]              fb_en,
    output logic [OFS_W-1:0]           ofs_code,
    output logic                       busy,
    output logic                       done,
    output logic                       cal_err,
    output logic                       cal_sat
);

    localparam int unsigned MW = $clog2(MULT + 1);
    localparam int unsigned AW = $clog2(AUX + 1);
    localparam int unsigned FW = $clog2(FB + 1);
    localparam int unsigned KW = (OFS_W > 1) ? $clog2(OFS_W) : 1;

    localparam logic [MW-1:0]    MAIN_MAX = MW'(MULT);
    localparam logic [AW-1:0]    AUX_MAX  = AW'(AUX);
    localparam logic [FW-1:0]    FB_MAX   = FW'(FB);
    localparam logic [OFS_W-1:0] OFS_MID  = OFS_W'(1) << (OFS_W - 1);
    localparam logic [KW-1:0]    K_TOP    = KW'(OFS_W - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StDecide} state_e;

    state_e                state_q, state_d;
    logic [MULT-1:0]       main_en_q, main_en_d;
    logic [AUX-1:0]        aux_en_q, aux_en_d;
    logic [FB-1:0]         fb_en_q, fb_en_d;
    logic [OFS_W-1:0]      ofs_q, ofs_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  sat_q, sat_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]         bit_q, bit_d;

    logic [MW-1:0]         main_cnt;
    logic [AW-1:0]         aux_cnt;
    logic [FW-1:0]         fb_cnt;
    logic                  main_nz;
    logic [SETTLE_W-1:0]   settle_eff;
    logic [OFS_W-1:0]      code;

    always_comb begin
        state_d   = state_q;
        main_en_d = main_en_q;
        aux_en_d  = aux_en_q;
        fb_en_d   = fb_en_q;
        ofs_d     = ofs_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        sat_d     = sat_q;
        settle_d  = settle_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        code      = ofs_q;

        main_cnt   = (cfg_main > MAIN_MAX) ? MAIN_MAX : cfg_main;
        aux_cnt    = (cfg_aux > AUX_MAX) ? AUX_MAX : cfg_aux;
        fb_cnt     = (cfg_fb > FB_MAX) ? FB_MAX : cfg_fb;
        // A same-cycle cfg_load takes effect before cal_start is judged.
        main_nz    = cfg_load ? (main_cnt != '0) : (main_en_q != '0);
        settle_eff = cfg_load ? cfg_settle : settle_q;

        unique case (state_q)
            StIdle: begin
                if (cfg_load) begin
                    main_en_d = ~({MULT{1'b1}} << main_cnt);
                    aux_en_d  = ~({AUX{1'b1}} << aux_cnt);
                    fb_en_d   = ~({FB{1'b1}} << fb_cnt);
                    settle_d  = cfg_settle;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    sat_d     = 1'b0;
                end
                if (cal_start) begin
                    if (main_nz) begin
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        sat_d   = 1'b0;
                        ofs_d   = OFS_MID;
                        bit_d   = K_TOP;
                        cnt_d   = settle_eff;
                        state_d = StSettle;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        sat_d  = 1'b0;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StDecide;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDecide: begin
                if (comp_i) begin
                    code[bit_q] = 1'b0;
                end
                if (bit_q != '0) begin
                    code[bit_q - 1'b1] = 1'b1;
                    bit_d   = bit_q - 1'b1;
                    cnt_d   = settle_q;
                    state_d = StSettle;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sat_d   = (code == '0) || (code == '1);
                    state_d = StIdle;
                end
                ofs_d = code;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            main_en_q <= '0;
            aux_en_q  <= '0;
            fb_en_q   <= '0;
            ofs_q     <= OFS_MID;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sat_q     <= 1'b0;
            settle_q  <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            main_en_q <= main_en_d;
            aux_en_q  <= aux_en_d;
            fb_en_q   <= fb_en_d;
            ofs_q     <= ofs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sat_q     <= sat_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
        end
    end

    assign main_en  = main_en_q;
    assign aux_en   = aux_en_q;
    assign fb_en    = fb_en_q;
    assign ofs_code = ofs_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cal_err  = err_q;
    assign cal_sat  = sat_q;

endmodule

// File: tb/tb_nauta_cal_ctrl.sv
// Self-checking bench for nauta_cal_ctrl: directed cases plus randomized config/calibration
// trials against a threshold-comparator model whose SAR result is the clamped threshold.
module tb_nauta_cal_ctrl;

    localparam int MULT  = 10;
    localparam int AUX   = 5;
    localparam int FB    = 4;
    localparam int OFS_W = 4;
    localparam int MID   = 8;
    localparam int TOP   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [3:0]  cfg_main = '0;
    logic [2:0]  cfg_aux = '0;
    logic [2:0]  cfg_fb = '0;
    logic [7:0]  cfg_settle = '0;
    logic        cal_start = 1'b0;
    logic        comp;
    logic [9:0]  main_en;
    logic [4:0]  aux_en;
    logic [3:0]  fb_en;
    logic [3:0]  ofs_code;
    logic        busy, done, cal_err, cal_sat;

    // Comparator model: output is "positive" when the trim code exceeds the threshold.
    int thr = 100;
    int exp_code = MID;
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] seq[$];

    assign comp = (int'(ofs_code) > thr);

    always #5 clk = ~clk;

    nauta_cal_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cfg_load   (cfg_load),
        .cfg_main   (cfg_main),
        .cfg_aux    (cfg_aux),
        .cfg_fb     (cfg_fb),
        .cfg_settle (cfg_settle),
        .cal_start  (cal_start),
        .comp_i     (comp),
        .main_en    (main_en),
        .aux_en     (aux_en),
        .fb_en      (fb_en),
        .ofs_code   (ofs_code),
        .busy       (busy),
        .done       (done),
        .cal_err    (cal_err),
        .cal_sat    (cal_sat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int therm(input int n, input int w);
        int m;
        m = (n > w) ? w : n;
        return (1 << m) - 1;
    endfunction

    function automatic int sar_result(input int t);
        if (t < 0) return 0;
        if (t > TOP) return TOP;
        return t;
    endfunction

    task automatic load(input int m, input int a, input int f, input int s);
        cfg_load   = 1'b1;
        cfg_main   = 4'(m);
        cfg_aux    = 3'(a);
        cfg_fb     = 3'(f);
        cfg_settle = 8'(s);
        step();
        cfg_load = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_main"}, 32'(main_en), 0);
        check({tag, "_aux"}, 32'(aux_en), 0);
        check({tag, "_fb"}, 32'(fb_en), 0);
        check({tag, "_ofs"}, 32'(ofs_code), MID);
        check({tag, "_flags"}, {28'd0, busy, done, cal_err, cal_sat}, 0);
    endtask

    // Starts a calibration and follows it to completion, checking against the model.
    task automatic run_cal(input string tag, input int s, input int t, input int em,
                           input int ea, input int ef);
        int n;
        int res;
        logic stable;
        thr = t;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        if (em == 0) begin
            check({tag, "_err_flags"}, {29'd0, busy, done, cal_err}, 32'b011);
            check({tag, "_err_ofs"}, 32'(ofs_code), 32'(exp_code));
            return;
        end
        check({tag, "_start_ofs"}, 32'(ofs_code), MID);
        n = 0;
        stable = 1'b1;
        seq.delete();
        seq.push_back(ofs_code);
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (ofs_code != seq[$]) seq.push_back(ofs_code);
            if (int'(main_en) != em || int'(aux_en) != ea || int'(fb_en) != ef) stable = 1'b0;
            step();
        end
        res = sar_result(t);
        check({tag, "_busy_len"}, 32'(n), 32'(OFS_W * (s + 2)));
        check({tag, "_en_stable"}, 32'(stable), 1);
        check({tag, "_code"}, 32'(ofs_code), 32'(res));
        check({tag, "_flags"}, {29'd0, busy, done, cal_err}, 32'b010);
        check({tag, "_sat"}, 32'(cal_sat), 32'((res == 0 || res == TOP) ? 1 : 0));
        exp_code = res;
    endtask

    initial begin
        int m, a, f, s, t, em, ea, ef, n;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_state("reset");

        load(7, 3, 4, 0);
        check("load_main", 32'(main_en), 32'h07F);
        check("load_aux", 32'(aux_en), 32'h07);
        check("load_fb", 32'(fb_en), 32'hF);
        check("load_ofs", 32'(ofs_code), MID);

        load(15, 7, 4, 2);
        check("sat_main", 32'(main_en), 32'h3FF);
        check("sat_aux", 32'(aux_en), 32'h1F);

        run_cal("sar5", 2, 5, 32'h3FF, 32'h1F, 32'hF);
        check("sar5_seq_len", 32'(seq.size()), 4);
        if (seq.size() == 4) begin
            check("sar5_seq", {16'd0, seq[0], seq[1], seq[2], seq[3]}, 32'h8465);
        end

        load(10, 5, 4, 0);
        run_cal("all0", 0, 100, 32'h3FF, 32'h1F, 32'hF);
        run_cal("all1", 0, -1, 32'h3FF, 32'h1F, 32'hF);

        // Same-cycle cfg_load and cal_start: new enables and new S are used.
        thr = 9;
        cfg_load = 1'b1;
        cfg_main = 4'd3;
        cfg_aux = 3'd1;
        cfg_fb = 3'd2;
        cfg_settle = 8'd1;
        run_cal("same_cyc", 1, 9, 32'h7, 32'h1, 32'h3);
        cfg_load = 1'b0;

        // Mid-calibration cfg_load and cal_start are ignored.
        load(10, 5, 4, 6);
        thr = 11;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            if (n == 4) begin
                cfg_load = 1'b1;
                cfg_main = 4'd1;
                cfg_aux = 3'd0;
                cfg_fb = 3'd0;
                cfg_settle = 8'd0;
                cal_start = 1'b1;
            end
            step();
            cfg_load = 1'b0;
            cal_start = 1'b0;
        end
        check("mid_busy_len", 32'(n), 32'(OFS_W * 8));
        check("mid_main", 32'(main_en), 32'h3FF);
        check("mid_aux", 32'(aux_en), 32'h1F);
        check("mid_code", 32'(ofs_code), 11);
        check("mid_done", 32'(done), 1);

        // done clears on cfg_load.
        load(10, 5, 4, 5);
        check("done_clr", {29'd0, done, cal_err, cal_sat}, 0);

        // Reset during SETTLE.
        thr = 3;
        cal_start = 1'b1;
        step();
        cal_start = 1'b0;
        step();
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rst_settle");
        exp_code = MID;

        // Calibration refused with no main segments.
        run_cal("refuse", 0, 5, 0, 0, 0);
        check("refuse_ofs", 32'(ofs_code), MID);

        for (int i = 0; i < 24; i++) begin
            m = int'($urandom_range(0, 15));
            a = int'($urandom_range(0, 7));
            f = int'($urandom_range(0, 7));
            s = int'($urandom_range(0, 6));
            t = int'($urandom_range(0, 18)) - 1;
            em = therm(m, MULT);
            ea = therm(a, AUX);
            ef = therm(f, FB);
            load(m, a, f, s);
            check($sformatf("rnd%0d_en", i), {2'd0, main_en, aux_en, fb_en, 11'd0},
                  32'((em << 20) | (ea << 15) | (ef << 11)));
            check($sformatf("rnd%0d_clr", i), {28'd0, busy, done, cal_err, cal_sat}, 0);
            check($sformatf("rnd%0d_ofs", i), 32'(ofs_code), 32'(exp_code));
            run_cal($sformatf("rnd%0d", i), s, t, em, ea, ef);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
